// File: rtl/double_buffer_reader.sv
// Port-B read sequencer for the Double_Buffer frame store: walks every address after a swap,
// waits out the RAM read latency, then streams each bank's word as valid/ready beats.
module double_buffer_reader #(
    parameter int ADDRESS_DEPTH = 8,
    parameter int BANK_COUNT    = 1,
    parameter int BANDWIDTH     = 8,
    parameter int READ_LATENCY  = 2,
    localparam int ADDR_W       = (ADDRESS_DEPTH > 1) ? $clog2(ADDRESS_DEPTH) : 1
) (
    input  logic                            clkb,
    input  logic                            rst_n,
    input  logic                            data_valid,
    input  logic                            frame_start,
    output logic [ADDR_W-1:0]               adb,
    output logic                            clk_data_out,
    input  logic [BANDWIDTH*BANK_COUNT-1:0] dout_flat,
    output logic [BANDWIDTH-1:0]            m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic                            m_last,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            abort
);

    localparam int BANK_W  = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;
    localparam int LAT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int SLICE_N = 1 << BANK_W;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ADDRESS_DEPTH - 1);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(BANK_COUNT - 1);
    localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        SEND,
        DONE
    } state_t;

    state_t                          state_q;
    logic [ADDR_W-1:0]               addr_q;
    logic [BANK_W-1:0]               bank_q;
    logic [LAT_W-1:0]                lat_q;
    logic [BANDWIDTH*BANK_COUNT-1:0] hold_q;
    logic [ADDR_W-1:0]               adb_q;
    logic                            clk_data_out_q;
    logic [BANDWIDTH-1:0]            m_data_q;
    logic                            m_valid_q;
    logic                            m_last_q;
    logic                            busy_q;
    logic                            frame_done_q;
    logic                            abort_q;

    logic [BANDWIDTH-1:0]            bank_slice [SLICE_N];
    logic [BANK_W-1:0]               next_bank;
    logic [ADDR_W-1:0]               next_addr;

    // Slice table padded to a power of two so a dynamic bank index never leaves the array.
    generate
        for (genvar gi = 0; gi < SLICE_N; gi++) begin : g_slice
            if (gi < BANK_COUNT) begin : g_real
                assign bank_slice[gi] = hold_q[gi*BANDWIDTH +: BANDWIDTH];
            end else begin : g_pad
                assign bank_slice[gi] = '0;
            end
        end
    endgenerate

    assign next_bank = bank_q + 1'b1;
    assign next_addr = addr_q + 1'b1;

    always_ff @(posedge clkb or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            bank_q         <= '0;
            lat_q          <= '0;
            hold_q         <= '0;
            adb_q          <= '0;
            clk_data_out_q <= 1'b0;
            m_data_q       <= '0;
            m_valid_q      <= 1'b0;
            m_last_q       <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            abort_q        <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_start && data_valid) begin
                        state_q        <= READ;
                        addr_q         <= '0;
                        adb_q          <= '0;
                        clk_data_out_q <= 1'b1;
                        busy_q         <= 1'b1;
                    end
                end
                READ, WAIT, SEND: begin
                    // Losing the frame mid-read abandons it; a beat accepted on this edge still counts.
                    if (!data_valid) begin
                        state_q        <= IDLE;
                        abort_q        <= 1'b1;
                        clk_data_out_q <= 1'b0;
                        m_valid_q      <= 1'b0;
                        m_last_q       <= 1'b0;
                        busy_q         <= 1'b0;
                    end else if (state_q == READ) begin
                        state_q        <= WAIT;
                        clk_data_out_q <= 1'b0;
                        lat_q          <= '0;
                    end else if (state_q == WAIT) begin
                        if (lat_q == LAST_LAT) begin
                            state_q   <= SEND;
                            hold_q    <= dout_flat;
                            bank_q    <= '0;
                            m_data_q  <= dout_flat[BANDWIDTH-1:0];
                            m_valid_q <= 1'b1;
                            m_last_q  <= (addr_q == LAST_ADDR) && (BANK_COUNT == 1);
                        end else begin
                            lat_q <= lat_q + 1'b1;
                        end
                    end else if (m_ready) begin
                        if (bank_q != LAST_BANK) begin
                            bank_q   <= next_bank;
                            m_data_q <= bank_slice[next_bank];
                            m_last_q <= (addr_q == LAST_ADDR) && (next_bank == LAST_BANK);
                        end else begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            if (addr_q != LAST_ADDR) begin
                                state_q        <= READ;
                                addr_q         <= next_addr;
                                adb_q          <= next_addr;
                                clk_data_out_q <= 1'b1;
                            end else begin
                                state_q      <= DONE;
                                frame_done_q <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign adb          = adb_q;
    assign clk_data_out = clk_data_out_q;
    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign m_last       = m_last_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign abort        = abort_q;

endmodule

// File: tb/tb_double_buffer_reader.sv
// Scoreboard bench for double_buffer_reader: stimulus pushes expected reads/beats,
// negedge monitors pop and compare. A second instance exercises two banks and a depth of 3.
module tb_double_buffer_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, data_valid, frame_start, clk_data_out, m_valid, m_ready, m_last;
    logic       busy, frame_done, abort;
    logic [2:0] adb;
    logic [7:0] dout_flat, m_data;

    logic        data_valid2, frame_start2, clk_data_out2, m_valid2, m_ready2, m_last2;
    logic        busy2, frame_done2, abort2;
    logic [1:0]  adb2;
    logic [15:0] dout_flat2;
    logic [7:0]  m_data2;

    double_buffer_reader dut (
        .clkb(clk), .rst_n(rst_n), .data_valid(data_valid), .frame_start(frame_start),
        .adb(adb), .clk_data_out(clk_data_out), .dout_flat(dout_flat), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .busy(busy),
        .frame_done(frame_done), .abort(abort)
    );

    double_buffer_reader #(.ADDRESS_DEPTH(3), .BANK_COUNT(2)) dut2 (
        .clkb(clk), .rst_n(rst_n), .data_valid(data_valid2), .frame_start(frame_start2),
        .adb(adb2), .clk_data_out(clk_data_out2), .dout_flat(dout_flat2), .m_data(m_data2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_last(m_last2), .busy(busy2),
        .frame_done(frame_done2), .abort(abort2)
    );

    // RAM models: word sampled on the read-enable edge, visible two edges after the enable rose
    logic [7:0]  mem  [8];
    logic [15:0] mem2 [3];
    logic [7:0]  s1, s2;
    logic [15:0] t1, t2;
    always @(posedge clk) begin
        if (clk_data_out) s1 <= mem[adb];
        s2 <= s1;
        if (clk_data_out2) t1 <= mem2[adb2];
        t2 <= t1;
    end
    assign dout_flat  = s2;
    assign dout_flat2 = t2;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_beat_q[$];
    logic [2:0] exp_addr_q[$];
    logic [8:0] exp_beat2_q[$];
    int done_cnt = 0, abort_cnt = 0, done2_cnt = 0, beats2 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the single-bank instance
    bit         prev_cdo, stall_pending, done_pending;
    logic [7:0] stall_data;
    logic [8:0] e;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cdo = 0; stall_pending = 0; done_pending = 0;
        end else begin
            if (clk_data_out) begin
                if (exp_addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: got adb %0d expected no read", adb);
                end else begin
                    chk("read_addr", adb, exp_addr_q.pop_front());
                end
                chk("read_pulse_width", prev_cdo, 0);
            end
            prev_cdo = clk_data_out;
            if (stall_pending && m_valid) chk("stall_data_stable", m_data, stall_data);
            stall_pending = m_valid && !m_ready;
            stall_data    = m_data;
            if (done_pending) chk("frame_done_after_last", frame_done, 1);
            done_pending = 0;
            if (m_valid && m_ready) begin
                if (exp_beat_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", m_data);
                end else begin
                    e = exp_beat_q.pop_front();
                    chk("beat_data", m_data, e[7:0]);
                    chk("beat_last", m_last, e[8]);
                    done_pending = m_last;
                end
            end
            if (frame_done) done_cnt++;
            if (abort) abort_cnt++;
        end
    end

    // Monitor for the two-bank instance
    logic [8:0] e2;
    always @(negedge clk) begin
        if (rst_n) begin
            if (clk_data_out2) chk("bank_read_after_all_beats", beats2, 2 * adb2);
            if (m_valid2 && m_ready2) begin
                if (exp_beat2_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat2: got %0h expected no beat", m_data2);
                end else begin
                    e2 = exp_beat2_q.pop_front();
                    chk("beat2_data", m_data2, e2[7:0]);
                    chk("beat2_last", m_last2, e2[8]);
                end
                beats2++;
            end
            if (frame_done2) done2_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input logic [7:0] base);
        for (int i = 0; i < 8; i++) begin
            mem[i] = base + 8'(i);
            exp_addr_q.push_back(3'(i));
            exp_beat_q.push_back({(i == 7), base + 8'(i)});
        end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done();
        int start;
        start = done_cnt;
        for (int i = 0; i < 300 && done_cnt == start; i++) tick();
        chk("frame_done_seen", done_cnt, start + 1);
        tick();
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50 && !m_valid; i++) tick();
        chk("valid_seen", m_valid, 1);
    endtask

    task automatic accept_one();
        wait_valid();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    logic [15:0] pat;
    int d0;
    initial begin
        rst_n = 1'b0; data_valid = 1'b0; frame_start = 1'b0; m_ready = 1'b0;
        data_valid2 = 1'b0; frame_start2 = 1'b0; m_ready2 = 1'b0;
        tick(); tick();
        chk("reset_outputs", {adb, clk_data_out, m_data, m_valid, m_last, busy, frame_done, abort}, 0);
        rst_n = 1'b1;
        tick();

        // Full frame, always ready, with first-valid latency
        data_valid = 1'b1; m_ready = 1'b1;
        load_frame(8'hA0);
        pulse_start();
        chk("busy_after_start", busy, 1);
        chk("read0_enable", clk_data_out, 1);
        tick(); tick();
        chk("no_valid_at_t3", m_valid, 0);
        tick();
        chk("valid_at_t4", m_valid, 1);
        chk("first_beat_data", m_data, 8'hA0);
        wait_done();
        chk("idle_after_frame", busy, 0);

        // Start request without a complete frame is dropped
        data_valid = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) begin chk("ignored_start_busy", busy, 0); tick(); end
        data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin chk("no_queued_start_busy", busy, 0); tick(); end

        // Two banks, depth 3
        for (int i = 0; i < 3; i++) begin
            mem2[i] = {8'hB1 + 8'(i), 8'hA1 + 8'(i)};
            exp_beat2_q.push_back({1'b0, 8'hA1 + 8'(i)});
            exp_beat2_q.push_back({(i == 2), 8'hB1 + 8'(i)});
        end
        data_valid2 = 1'b1; m_ready2 = 1'b1;
        frame_start2 = 1'b1;
        tick();
        frame_start2 = 1'b0;
        for (int i = 0; i < 100 && done2_cnt == 0; i++) tick();
        chk("bank2_frame_done", done2_cnt, 1);
        chk("bank2_beat_count", beats2, 6);

        // Backpressure
        load_frame(8'hC0);
        pat = 16'b1001_0110_0011_0101;
        m_ready = 1'b0;
        pulse_start();
        d0 = done_cnt;
        for (int i = 0; i < 300 && done_cnt == d0; i++) begin
            m_ready = pat[i % 16];
            tick();
        end
        chk("backpressure_done", done_cnt, d0 + 1);
        m_ready = 1'b1;
        tick();

        // Abort while the third beat is presented
        for (int i = 0; i < 8; i++) mem[i] = 8'hD0 + 8'(i);
        exp_addr_q.push_back(3'd0); exp_addr_q.push_back(3'd1); exp_addr_q.push_back(3'd2);
        exp_beat_q.push_back({1'b0, 8'hD0}); exp_beat_q.push_back({1'b0, 8'hD1});
        m_ready = 1'b0;
        d0 = done_cnt;
        pulse_start();
        accept_one();
        accept_one();
        wait_valid();
        chk("third_beat_data", m_data, 8'hD2);
        data_valid = 1'b0;
        tick();
        chk("abort_pulse", abort, 1);
        chk("abort_valid_low", m_valid, 0);
        chk("abort_busy_low", busy, 0);
        tick();
        chk("abort_one_cycle", abort, 0);
        chk("abort_no_frame_done", done_cnt, d0);
        data_valid = 1'b1; m_ready = 1'b1;
        load_frame(8'hE0);
        pulse_start();
        wait_done();

        // Asynchronous reset during WAIT
        mem[0] = 8'h55;
        exp_addr_q.push_back(3'd0);
        pulse_start();
        tick();
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", {adb, clk_data_out, m_data, m_valid, m_last, busy, frame_done, abort}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        load_frame(8'hF0);
        pulse_start();
        wait_done();

        chk("beat_queue_empty", exp_beat_q.size(), 0);
        chk("addr_queue_empty", exp_addr_q.size(), 0);
        chk("beat2_queue_empty", exp_beat2_q.size(), 0);
        chk("total_frame_done", done_cnt, 4);
        chk("total_abort", abort_cnt, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
